// File: rtl/conf_int_mac_acc_seq.sv
// Two-stage streaming multiply-accumulate sequencer driving an external combinational MAC.
// Optional reduced-precision operand mode is enabled by defining CONF_INT_MAC_ACC_SEQ_APX_EN.
module conf_int_mac_acc_seq #(
  parameter int DATA_PATH_BITWIDTH = 16,
  parameter int Pn                 = 4,
  parameter int CNT_W              = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
  input  logic                          cfg_apx,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  input  logic                          in_last,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_c,
  input  logic [DATA_PATH_BITWIDTH-1:0] mac_d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] out_data,
  output logic [CNT_W-1:0]              out_count
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam logic [DW-1:0] LOW_MASK = {{(DW-Pn){1'b1}}, {Pn{1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t          state_q, state_d;
  logic            v1_q, v1_d;
  logic            first1_q, first1_d;
  logic            last1_q, last1_d;
  logic [DW-1:0]   mac_a_q, mac_a_d;
  logic [DW-1:0]   mac_b_q, mac_b_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic            apx_sel;
  logic [DW-1:0]   op_mask;
  logic            stall;
  logic            xfer;
  logic            capture;

`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
  assign apx_sel = cfg_apx;
`else
  assign apx_sel = 1'b0;
`endif

  assign op_mask  = apx_sel ? LOW_MASK : {DW{1'b1}};
  // A finished vector that cannot hand its result over blocks the whole pipe.
  assign stall    = v1_q & last1_q & out_valid_q & ~out_ready;
  assign in_ready = rst & ~stall;
  assign xfer     = in_valid & in_ready;
  assign capture  = v1_q & last1_q & ~stall;

  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = first1_q ? {DW{1'b0}} : acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  always_comb begin
    state_d     = state_q;
    v1_d        = v1_q;
    first1_d    = first1_q;
    last1_d     = last1_q;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    cnt1_d      = cnt1_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;

    if (!stall) begin
      v1_d = xfer;
      if (v1_q) begin
        acc_d = mac_d;
      end
    end

    if (xfer) begin
      mac_a_d  = in_a & op_mask;
      mac_b_d  = in_b & op_mask;
      first1_d = (state_q == IDLE);
      last1_d  = in_last;
      if (state_q == IDLE) begin
        cnt1_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt1_q != {CNT_W{1'b1}}) begin
        cnt1_d = cnt1_q + 1'b1;
      end
      case (state_q)
        IDLE:    state_d = in_last ? IDLE : ACCUM;
        ACCUM:   state_d = in_last ? IDLE : ACCUM;
        default: state_d = IDLE;
      endcase
    end

    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = mac_d;
      out_count_d = cnt1_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      v1_q        <= 1'b0;
      first1_q    <= 1'b0;
      last1_q     <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      cnt1_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      v1_q        <= v1_d;
      first1_q    <= first1_d;
      last1_q     <= last1_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      cnt1_q      <= cnt1_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_conf_int_mac_acc_seq.sv
// Directed bench for conf_int_mac_acc_seq with a behavioural downstream MAC and result scoreboard.
module tb_conf_int_mac_acc_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_a, in_b;
  logic [15:0] mac_a, mac_b, mac_c, mac_d;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic [7:0]  out_count;
`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
  logic        cfg_apx;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [15:0] q_data[$];
  logic [7:0]  q_cnt[$];
  int          q_cyc[$];

  always #5 clk = ~clk;

  // Downstream combinational MAC, truncated to 16 bits.
  assign mac_d = mac_a * mac_b + mac_c;

  conf_int_mac_acc_seq #(.DATA_PATH_BITWIDTH(16), .Pn(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
    .cfg_apx(cfg_apx),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_cnt.push_back(out_count);
      q_cyc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    q_data.delete();
    q_cnt.delete();
    q_cyc.delete();
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    tick();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_a = 16'hDEAD;
    in_b = 16'hBEEF;
    in_last = 1'b1;
    repeat (n) tick();
  endtask

  task automatic expect_result(input string name, input logic [15:0] d, input logic [7:0] c);
    checks++;
    if (q_data.size() == 0) begin
      errors++;
      $display("FAIL %s: no result, required data=%h count=%0d", name, d, c);
    end else begin
      logic [15:0] gd;
      logic [7:0]  gc;
      gd = q_data.pop_front();
      gc = q_cnt.pop_front();
      void'(q_cyc.pop_front());
      if (gd !== d || gc !== c) begin
        errors++;
        $display("FAIL %s: data=%h count=%0d required data=%h count=%0d", name, gd, gc, d, c);
      end else begin
        $display("txn %s: data=%h count=%0d", name, gd, gc);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, out_data, out_count, mac_a, mac_b, mac_c} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b ov=%b od=%h oc=%0d a=%h b=%h c=%h required all 0",
               in_ready, out_valid, out_data, out_count, mac_a, mac_b, mac_c);
    end else $display("txn reset: outputs zero");
  endtask

  task automatic test_single_term();
    clear_q();
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = 16'd3; in_b = 16'd5; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b required 0 after 1 edge", out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'd15 || out_count !== 8'd1) begin
      errors++;
      $display("FAIL single_term: ov=%b data=%0d count=%0d required ov=1 data=15 count=1",
               out_valid, out_data, out_count);
    end else $display("txn single_term: data=%0d count=%0d", out_data, out_count);
    idle(3);
    clear_q();
  endtask

  task automatic test_back_to_back();
    int c0;
    clear_q();
    out_ready = 1'b1;
    send(16'd2, 16'd3, 1'b0);
    send(16'd4, 16'd5, 1'b0);
    send(16'd1, 16'd7, 1'b1);
    send(16'd6, 16'd6, 1'b1);
    idle(4);
    checks++;
    if (q_cyc.size() != 2 || (q_cyc[1] - q_cyc[0]) != 1) begin
      errors++;
      $display("FAIL b2b_spacing: results=%0d required 2 one cycle apart", q_cyc.size());
    end
    c0 = 0;
    expect_result("b2b_first", 16'd33, 8'd3);
    expect_result("b2b_second", 16'd36, 8'd1);
    checks++;
    if (mac_a !== 16'd6 || mac_b !== 16'd6) begin
      errors++;
      $display("FAIL hold_when_invalid: mac_a=%h mac_b=%h required 0006 0006", mac_a, mac_b);
    end
  endtask

  task automatic test_stall();
    clear_q();
    out_ready = 1'b0;
    send(16'd1, 16'd2, 1'b1);
    send(16'd3, 16'd4, 1'b0);
    send(16'd5, 16'd6, 1'b1);
    in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7; in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b0 || mac_c !== 16'd12 || mac_a !== 16'd5 || out_data !== 16'd2) begin
        errors++;
        $display("FAIL stall_hold: rdy=%b mac_c=%0d mac_a=%0d od=%0d required 0 12 5 2",
                 in_ready, mac_c, mac_a, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: in_ready=%b required 1", in_ready);
    end
    tick();
    idle(4);
    expect_result("stall_first", 16'd2, 8'd1);
    expect_result("stall_second", 16'd42, 8'd2);
    expect_result("stall_third", 16'd49, 8'd1);
  endtask

  task automatic test_wrap();
    clear_q();
    out_ready = 1'b1;
    send(16'hFFFF, 16'd2, 1'b0);
    send(16'd1, 16'd3, 1'b1);
    idle(3);
    expect_result("wrap", 16'h0001, 8'd2);
  endtask

  task automatic test_mid_reset();
    clear_q();
    out_ready = 1'b1;
    send(16'd1, 16'd1, 1'b0);
    send(16'd2, 16'd2, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, out_data, out_count, mac_a, mac_b, mac_c} !== '0) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b ov=%b od=%h oc=%0d a=%h b=%h c=%h required all 0",
               in_ready, out_valid, out_data, out_count, mac_a, mac_b, mac_c);
    end
    tick();
    rst = 1'b1;
    tick();
    send(16'd1, 16'd1, 1'b1);
    idle(3);
    expect_result("after_reset", 16'd1, 8'd1);
  endtask

  task automatic test_saturate();
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < 299; i++) send(16'd0, 16'd0, 1'b0);
    send(16'd1, 16'd1, 1'b1);
    idle(3);
    expect_result("count_saturate", 16'd1, 8'd255);
  endtask

`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
  task automatic test_apx();
    clear_q();
    out_ready = 1'b1;
    cfg_apx = 1'b1;
    send(16'h0013, 16'h0021, 1'b1);
    cfg_apx = 1'b0;
    send(16'h0013, 16'h0021, 1'b1);
    idle(3);
    expect_result("apx_on", 16'h0200, 8'd1);
    expect_result("apx_off", 16'h0273, 8'd1);
  endtask
`endif

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    out_ready = 1'b0;
`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
    cfg_apx = 1'b0;
`endif
    repeat (2) tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_single_term();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_mid_reset();
    test_saturate();
`ifdef CONF_INT_MAC_ACC_SEQ_APX_EN
    test_apx();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
